// File: rtl/adsb_ts_pkg.sv
// Shared widths, FSM state encodings, timeout defaults and the timestamp record
// for the ADS-B timestamp sequencer.
package adsb_ts_pkg;

  localparam int DEF_UTC_SECONDS_WIDTH       = 6;
  localparam int DEF_COUNT_LAST_SECOND_WIDTH = 26;
  localparam int DEF_DRIFT_COUNT_WIDTH       = 13;
  localparam int DEF_CRC_TIMEOUT             = 7680;
  localparam int DEF_READY_TIMEOUT           = 4;
  localparam int DEF_FIFO_DEPTH              = 4;
  localparam int DEF_STAT_WIDTH              = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WAIT_CRC   = 2'd1;
  localparam state_t ST_WAIT_READY = 2'd2;

  // Field order matches the queue word: UTC second in the MSBs, drift in the LSBs.
  typedef struct packed {
    logic        [DEF_UTC_SECONDS_WIDTH-1:0]       utc_seconds;
    logic        [DEF_COUNT_LAST_SECOND_WIDTH-1:0] clk_counter;
    logic signed [DEF_DRIFT_COUNT_WIDTH-1:0]       drift;
  } ts_rec_t;

endpackage

// File: rtl/adsb_ts_fifo.sv
// Synchronous first-word-fall-through FIFO; a push into a full queue is
// accepted when a pop happens in the same cycle.
module adsb_ts_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero while empty so the unreset storage never reaches the ports.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; only the pointers define validity, so resetting
  // the array would just add reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adsb_ts_sequencer.sv
// Turns preamble strobes into timestamp-unit capture requests, commits them on
// CRC pass and queues committed timestamps for the host reader.
module adsb_ts_sequencer
  import adsb_ts_pkg::*;
#(
  parameter int UTC_SECONDS_WIDTH       = DEF_UTC_SECONDS_WIDTH,
  parameter int COUNT_LAST_SECOND_WIDTH = DEF_COUNT_LAST_SECOND_WIDTH,
  parameter int DRIFT_COUNT_WIDTH       = DEF_DRIFT_COUNT_WIDTH,
  parameter int CRC_TIMEOUT             = DEF_CRC_TIMEOUT,
  parameter int READY_TIMEOUT           = DEF_READY_TIMEOUT,
  parameter int FIFO_DEPTH              = DEF_FIFO_DEPTH,
  parameter int STAT_WIDTH              = DEF_STAT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                preamble_det,
  input  logic                                crc_done,
  input  logic                                crc_ok,
  output logic                                ts_event,
  output logic                                ts_confirm,
  input  logic                                ts_ready,
  input  logic [UTC_SECONDS_WIDTH-1:0]        ts_utc_seconds,
  input  logic [COUNT_LAST_SECOND_WIDTH-1:0]  ts_clk_counter,
  input  logic signed [DRIFT_COUNT_WIDTH-1:0] ts_drift,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [UTC_SECONDS_WIDTH-1:0]        out_utc_seconds,
  output logic [COUNT_LAST_SECOND_WIDTH-1:0]  out_clk_counter,
  output logic signed [DRIFT_COUNT_WIDTH-1:0] out_drift,
  output logic                                busy,
  output logic [STAT_WIDTH-1:0]               cnt_crc_fail,
  output logic [STAT_WIDTH-1:0]               cnt_timeout,
  output logic [STAT_WIDTH-1:0]               cnt_busy_drop,
  output logic [STAT_WIDTH-1:0]               cnt_overflow
);

  localparam int REC_W = UTC_SECONDS_WIDTH + COUNT_LAST_SECOND_WIDTH + DRIFT_COUNT_WIDTH;
  localparam int T_MAX = (CRC_TIMEOUT > READY_TIMEOUT) ? CRC_TIMEOUT : READY_TIMEOUT;
  localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  state_t     state;
  logic [TW-1:0] timer;
  logic       crc_to_hit;
  logic       rdy_to_hit;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;
  logic       inc_crc_fail;
  logic       inc_timeout;
  logic       inc_busy_drop;
  logic       inc_overflow;
  logic [REC_W-1:0] head;

  assign crc_to_hit = (timer == TW'(CRC_TIMEOUT - 1));
  assign rdy_to_hit = (timer == TW'(READY_TIMEOUT - 1));
  assign busy       = (state != ST_IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    push          = 1'b0;
    inc_crc_fail  = 1'b0;
    inc_timeout   = 1'b0;
    inc_busy_drop = preamble_det && (state != ST_IDLE);
    case (state)
      ST_WAIT_CRC: begin
        inc_crc_fail = crc_done && !crc_ok;
        inc_timeout  = !crc_done && crc_to_hit;
      end
      ST_WAIT_READY: begin
        push        = ts_ready;
        inc_timeout = !ts_ready && rdy_to_hit;
      end
      default: ;
    endcase
    // A full queue still accepts when the reader pops in the same cycle.
    inc_overflow = push && fifo_full && !out_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      timer      <= '0;
      ts_event   <= 1'b0;
      ts_confirm <= 1'b0;
    end else begin
      ts_event   <= 1'b0;
      ts_confirm <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (preamble_det) begin
            ts_event <= 1'b1;
            timer    <= '0;
            state    <= ST_WAIT_CRC;
          end
        end
        ST_WAIT_CRC: begin
          timer <= timer + TW'(1);
          if (crc_done) begin
            if (crc_ok) begin
              ts_confirm <= 1'b1;
              timer      <= '0;
              state      <= ST_WAIT_READY;
            end else begin
              state <= ST_IDLE;
            end
          end else if (crc_to_hit) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT_READY: begin
          timer <= timer + TW'(1);
          if (ts_ready || rdy_to_hit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Drop statistics saturate at all-ones and clear only on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_crc_fail  <= '0;
      cnt_timeout   <= '0;
      cnt_busy_drop <= '0;
      cnt_overflow  <= '0;
    end else begin
      if (inc_crc_fail  && (cnt_crc_fail  != '1)) cnt_crc_fail  <= cnt_crc_fail  + STAT_WIDTH'(1);
      if (inc_timeout   && (cnt_timeout   != '1)) cnt_timeout   <= cnt_timeout   + STAT_WIDTH'(1);
      if (inc_busy_drop && (cnt_busy_drop != '1)) cnt_busy_drop <= cnt_busy_drop + STAT_WIDTH'(1);
      if (inc_overflow  && (cnt_overflow  != '1)) cnt_overflow  <= cnt_overflow  + STAT_WIDTH'(1);
    end
  end

  adsb_ts_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({ts_utc_seconds, ts_clk_counter, ts_drift}),
    .pop     (out_ready),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid       = !fifo_empty;
  assign out_utc_seconds = head[REC_W-1 -: UTC_SECONDS_WIDTH];
  assign out_clk_counter = head[DRIFT_COUNT_WIDTH +: COUNT_LAST_SECOND_WIDTH];
  assign out_drift       = head[DRIFT_COUNT_WIDTH-1:0];

endmodule

// File: tb/tb_adsb_ts_sequencer.sv
// Self-checking bench for adsb_ts_sequencer: capture-vector table plus
// directed sequences for timeouts, busy drops, overflow and reset.
module tb_adsb_ts_sequencer;
  import adsb_ts_pkg::*;

  localparam int CRC_TO = 7680;
  localparam int RDY_TO = 4;
  localparam int DEPTH  = 4;
  localparam int SW     = 16;

  typedef struct {
    logic [5:0]         utc;
    logic [25:0]        cc;
    logic signed [12:0] drift;
    int                 gap;
    bit                 ok;
    int                 rdly;
    bit                 pop_at_ready;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, preamble_det, crc_done, crc_ok, ts_ready, out_ready;
  logic ts_event, ts_confirm, out_valid, busy;
  logic [5:0]         ts_utc_seconds, out_utc_seconds;
  logic [25:0]        ts_clk_counter, out_clk_counter;
  logic signed [12:0] ts_drift, out_drift;
  logic [SW-1:0]      cnt_crc_fail, cnt_timeout, cnt_busy_drop, cnt_overflow;

  int n_cmp = 0, n_fail = 0;
  int exp_crc_fail = 0, exp_timeout = 0, exp_busy_drop = 0, exp_overflow = 0;
  int ev_cnt = 0, cf_cnt = 0, viol = 0;
  bit prev_ev = 1'b0, prev_cf = 1'b0;
  ts_rec_t sb[$];
  vec_t    vecs[6];

  always #5 clk = ~clk;

  adsb_ts_sequencer #(
    .UTC_SECONDS_WIDTH(6), .COUNT_LAST_SECOND_WIDTH(26), .DRIFT_COUNT_WIDTH(13),
    .CRC_TIMEOUT(CRC_TO), .READY_TIMEOUT(RDY_TO), .FIFO_DEPTH(DEPTH), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .preamble_det(preamble_det), .crc_done(crc_done),
    .crc_ok(crc_ok), .ts_event(ts_event), .ts_confirm(ts_confirm), .ts_ready(ts_ready),
    .ts_utc_seconds(ts_utc_seconds), .ts_clk_counter(ts_clk_counter), .ts_drift(ts_drift),
    .out_valid(out_valid), .out_ready(out_ready), .out_utc_seconds(out_utc_seconds),
    .out_clk_counter(out_clk_counter), .out_drift(out_drift), .busy(busy),
    .cnt_crc_fail(cnt_crc_fail), .cnt_timeout(cnt_timeout),
    .cnt_busy_drop(cnt_busy_drop), .cnt_overflow(cnt_overflow)
  );

  // Pulse monitor: counts strobes and flags overlap or back-to-back highs.
  always @(negedge clk) begin
    if (ts_event && ts_confirm) viol++;
    if ((ts_event && prev_ev) || (ts_confirm && prev_cf)) viol++;
    ev_cnt += int'(ts_event);
    cf_cnt += int'(ts_confirm);
    prev_ev = ts_event;
    prev_cf = ts_confirm;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_vec(input logic [5:0] utc, input logic [25:0] cc,
                                  input logic signed [12:0] drift, input int gap,
                                  input bit ok, input int rdly, input bit pop_at_ready);
    vec_t v;
    v.utc = utc; v.cc = cc; v.drift = drift; v.gap = gap;
    v.ok = ok; v.rdly = rdly; v.pop_at_ready = pop_at_ready;
    return v;
  endfunction

  function automatic logic [63:0] head_word();
    return 64'({out_utc_seconds, out_clk_counter, out_drift});
  endfunction

  task automatic pop_head(input string name);
    ts_rec_t e;
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(name, head_word(), 64'(e));
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_crc_fail"},  64'(cnt_crc_fail),  64'(exp_crc_fail));
    check({tag, "_timeout"},   64'(cnt_timeout),   64'(exp_timeout));
    check({tag, "_busy_drop"}, 64'(cnt_busy_drop), 64'(exp_busy_drop));
    check({tag, "_overflow"},  64'(cnt_overflow),  64'(exp_overflow));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ts_event"},   64'(ts_event),   64'(0));
    check({tag, "_ts_confirm"}, 64'(ts_confirm), 64'(0));
    check({tag, "_out_valid"},  64'(out_valid),  64'(0));
    check({tag, "_busy"},       64'(busy),       64'(0));
    check({tag, "_fields"},     head_word(),     64'(0));
    check_counters(tag);
  endtask

  // One capture: preamble, CRC verdict after v.gap cycles, ts_ready v.rdly cycles after the verdict.
  task automatic apply_vec(input vec_t v);
    ts_rec_t rec;
    preamble_det = 1'b1;
    tick();
    preamble_det = 1'b0;
    check("ts_event_rise", 64'(ts_event), 64'(1));
    check("busy_set", 64'(busy), 64'(1));
    for (int i = 1; i < v.gap; i++) tick();
    crc_done = 1'b1;
    crc_ok   = v.ok;
    tick();
    crc_done = 1'b0;
    crc_ok   = 1'b0;
    check("ts_confirm", 64'(ts_confirm), 64'(v.ok));
    check("ts_event_single", 64'(ts_event), 64'(0));
    if (!v.ok) begin
      exp_crc_fail++;
      check("busy_after_fail", 64'(busy), 64'(0));
      return;
    end
    for (int i = 1; i < v.rdly; i++) tick();
    ts_ready       = 1'b1;
    ts_utc_seconds = v.utc;
    ts_clk_counter = v.cc;
    ts_drift       = v.drift;
    rec.utc_seconds = v.utc;
    rec.clk_counter = v.cc;
    rec.drift       = v.drift;
    if (v.pop_at_ready) begin
      out_ready = 1'b1;
      pop_head("head_at_push");
    end
    if (v.rdly <= RDY_TO) begin
      if (sb.size() < DEPTH) sb.push_back(rec);
      else exp_overflow++;
    end else begin
      exp_timeout++;
    end
    tick();
    ts_ready  = 1'b0;
    out_ready = 1'b0;
    check("busy_after_ready", 64'(busy), 64'(0));
    check("out_valid_after", 64'(out_valid), 64'(sb.size() != 0));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 2 * DEPTH && sb.size() > 0; i++) begin
      out_ready = 1'b1;
      pop_head({tag, "_head"});
      tick();
    end
    out_ready = 1'b0;
    check({tag, "_empty"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    int ev0, cf0;
    rst_n = 1'b0; preamble_det = 1'b0; crc_done = 1'b0; crc_ok = 1'b0;
    ts_ready = 1'b0; out_ready = 1'b0;
    ts_utc_seconds = '0; ts_clk_counter = '0; ts_drift = '0;
    repeat (3) tick();
    check_reset("rst");
    rst_n = 1'b1;
    repeat (2) tick();

    vecs[0] = mk_vec(6'd12, 26'd1000,     -13'sd3,    90, 1'b1, 2, 1'b0);
    vecs[1] = mk_vec(6'd5,  26'h3FFFFFF,  -13'sd4096, 1,  1'b1, 1, 1'b0);
    vecs[2] = mk_vec(6'd63, 26'd0,        13'sd4095,  3,  1'b1, 4, 1'b0);
    vecs[3] = mk_vec(6'd1,  26'd2,        13'sd3,     2,  1'b1, 5, 1'b0);
    vecs[4] = mk_vec(6'd7,  26'd7,        13'sd7,     4,  1'b0, 0, 1'b0);
    vecs[5] = mk_vec(6'd33, 26'd123456,   -13'sd1,    10, 1'b1, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply_vec(vecs[i]);
      tick();
    end
    check_counters("table");
    drain("table");

    // Second preamble while busy is dropped and produces no second ts_event.
    ev0 = ev_cnt;
    preamble_det = 1'b1; tick(); preamble_det = 1'b0;
    repeat (4) tick();
    preamble_det = 1'b1; tick(); preamble_det = 1'b0;
    crc_done = 1'b1; crc_ok = 1'b0; tick(); crc_done = 1'b0;
    exp_busy_drop++;
    exp_crc_fail++;
    check("busy_drop_idle", 64'(busy), 64'(0));
    check("busy_drop_events", 64'(ev_cnt - ev0), 64'(1));
    check_counters("busy_drop");
    tick();

    // No CRC verdict at all: WAIT_CRC lasts exactly CRC_TO cycles.
    cf0 = cf_cnt;
    preamble_det = 1'b1; tick(); preamble_det = 1'b0;
    repeat (CRC_TO - 1) tick();
    check("crc_to_last_busy", 64'(busy), 64'(1));
    tick();
    exp_timeout++;
    check("crc_to_idle", 64'(busy), 64'(0));
    check("crc_to_no_confirm", 64'(cf_cnt - cf0), 64'(0));
    check_counters("crc_to");
    tick();

    // Verdict on the final timeout cycle wins over the timeout.
    apply_vec(mk_vec(6'd44, 26'd4444, -13'sd44, CRC_TO, 1'b1, 2, 1'b0));
    check_counters("crc_edge");
    drain("crc_edge");

    // Five captures into a stalled reader, then a push with a simultaneous pop.
    for (int i = 0; i < 5; i++) begin
      apply_vec(mk_vec(6'(i + 1), 26'(100 * (i + 1)), 13'(-i), 2 + i, 1'b1, 2, 1'b0));
      tick();
    end
    check("ovf_full_valid", 64'(out_valid), 64'(1));
    check_counters("ovf");
    apply_vec(mk_vec(6'd50, 26'd5050, 13'sd50, 3, 1'b1, 2, 1'b1));
    check_counters("ovf_pop");
    drain("ovf");

    // Reset during WAIT_READY with two entries queued.
    apply_vec(mk_vec(6'd20, 26'd2020, 13'sd20, 2, 1'b1, 1, 1'b0));
    apply_vec(mk_vec(6'd21, 26'd2121, 13'sd21, 2, 1'b1, 3, 1'b0));
    tick();
    preamble_det = 1'b1; tick(); preamble_det = 1'b0;
    crc_done = 1'b1; crc_ok = 1'b1; tick(); crc_done = 1'b0; crc_ok = 1'b0;
    check("pre_rst_confirm", 64'(ts_confirm), 64'(1));
    rst_n = 1'b0;
    tick();
    sb.delete();
    exp_crc_fail = 0; exp_timeout = 0; exp_busy_drop = 0; exp_overflow = 0;
    check_reset("mid_rst");
    rst_n = 1'b1;
    ts_ready = 1'b1; ts_utc_seconds = 6'd9; ts_clk_counter = 26'd9; ts_drift = 13'sd9;
    tick();
    ts_ready = 1'b0;
    tick();
    check("late_ready_no_push", 64'(out_valid), 64'(0));
    check("late_ready_idle", 64'(busy), 64'(0));

    check("strobe_rules", 64'(viol), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
